i2c_scl_gen: RTL

Parametrised I2C SCL generator for the master datapath. Adds a selectable duty-cycle mode, slave clock-stretch tracking, multi-master clock synchronisation and bus-clear detection. Uses split scl_i/scl_oe/scl_o pins; the top-level pad ties these to the open-drain or push-pull buffer. Emits edge strobes that the byte engine uses to launch and sample SDA.

---
 rtl/i2c_scl_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: LOW/HIGH phase timing, slave clock-stretch tracking,
// multi-master synchronisation and bus-clear detection. All outputs are registered.
module i2c_scl_gen #(
  parameter int unsigned INPUT_CLK_RATE      = 50_000_000,
  parameter int unsigned TARGET_SCL_RATE     = 100_000,
  parameter int unsigned SLOWEST_MASTER_RATE = 50_000,
  parameter int unsigned MODE                = 0,
  parameter bit          PUSH_PULL           = 1'b0,
  parameter bit          MULTI_MASTER        = 1'b1,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic enable,
  input  logic scl_i,
  output logic scl_oe,
  output logic scl_o,
  output logic scl_fall,
  output logic scl_rise,
  output logic busy,
  output logic stretching,
  output logic bus_clear
);

  localparam int unsigned P          = INPUT_CLK_RATE / TARGET_SCL_RATE;
  localparam int unsigned W          = 2 * INPUT_CLK_RATE / SLOWEST_MASTER_RATE;
  localparam int unsigned LowCycles  = (MODE == 1) ? (2 * P) / 3 : P / 2;
  localparam int unsigned HighCycles = P - LowCycles;
  localparam int unsigned CntW       = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned WaitW      = $clog2(W + 1);

  localparam logic [CntW-1:0]  LowLast    = CntW'(LowCycles - 1);
  localparam logic [CntW-1:0]  HighLast   = CntW'(HighCycles - 1);
  localparam logic [WaitW-1:0] WaitMax    = WaitW'(W);
  // Held-low time beyond the normal release-to-sync latency counts as a stretch.
  localparam logic [WaitW-1:0] StretchThr = WaitW'(SYNC_STAGES + 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               seen_q, seen_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               scl_oe_q, scl_o_q, fall_q, rise_q, busy_q, stretch_q, clear_q;
  logic               fall_d, rise_d, stretch_d, clear_d;
  logic               scl_s;

  // In push-pull mode the pad level is whatever we drive, so no external influence.
  assign scl_s = PUSH_PULL ? ~scl_oe_q : sync_q[SYNC_STAGES-1];

  // Pad synchroniser; resets to the idle (released, high) bus level.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], scl_i};
  end

  // Phase sequencing, stretch/stall accounting and strobe generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    seen_d    = seen_q;
    fall_d    = 1'b0;
    rise_d    = 1'b0;
    stretch_d = 1'b0;
    clear_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        wait_d = '0;
        seen_d = 1'b0;
        // A low bus while idle means someone else owns it; wait for release.
        if (enable && scl_s) begin
          state_d = StLow;
          fall_d  = 1'b1;
        end
      end
      StLow: begin
        if (cnt_q == LowLast) begin
          state_d = StHigh;
          cnt_d   = '0;
          seen_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (!scl_s && seen_q && MULTI_MASTER) begin
          // Another master pulled SCL low first: resynchronise to its LOW phase.
          state_d = StLow;
          cnt_d   = '0;
          wait_d  = '0;
          seen_d  = 1'b0;
          fall_d  = 1'b1;
        end else if (!scl_s) begin
          // Held low externally (or rise latency): freeze the phase counter.
          if (wait_q != WaitMax) wait_d = wait_q + 1'b1;
          stretch_d = (wait_d > StretchThr);
          clear_d   = (wait_d == WaitMax);
        end else begin
          wait_d = '0;
          seen_d = 1'b1;
          rise_d = !seen_q;
          if (cnt_q == HighLast) begin
            cnt_d  = '0;
            seen_d = 1'b0;
            if (enable) begin
              state_d = StLow;
              fall_d  = 1'b1;
              rise_d  = 1'b0;  // fall wins if H is a single cycle
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (PUSH_PULL) begin
      stretch_d = 1'b0;
      clear_d   = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wait_q    <= '0;
      seen_q    <= 1'b0;
      scl_oe_q  <= 1'b0;
      scl_o_q   <= 1'b0;
      fall_q    <= 1'b0;
      rise_q    <= 1'b0;
      busy_q    <= 1'b0;
      stretch_q <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      seen_q    <= seen_d;
      scl_oe_q  <= (state_d == StLow);
      scl_o_q   <= PUSH_PULL && (state_d == StHigh);
      fall_q    <= fall_d;
      rise_q    <= rise_d;
      busy_q    <= (state_d != StIdle);
      stretch_q <= stretch_d;
      clear_q   <= clear_d;
    end
  end

  assign scl_oe     = scl_oe_q;
  assign scl_o      = scl_o_q;
  assign scl_fall   = fall_q;
  assign scl_rise   = rise_q;
  assign busy       = busy_q;
  assign stretching = stretch_q;
  assign bus_clear  = clear_q;

endmodule
